// File: rtl/spi_pkg.sv
// Shared frame constants and FSM state encoding for the SPI register bridge.
package spi_pkg;

  localparam int FRAME_BITS = 32;
  localparam int HDR_BITS   = 16;
  localparam int RW_BIT     = 31;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RDLAT,
    DATA,
    DONE
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with registered rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave that turns 32-bit frames into register bus accesses.
module spi_bus_bridge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic [DATA_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_wr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_frame_err
);

  localparam logic [4:0] HDR_END   = 5'(HDR_BITS - 1);
  localparam logic [4:0] FRAME_END = 5'(FRAME_BITS - 1);

  logic sclk_lvl_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_s;
  logic cs_rise;
  logic cs_fall;

  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;

  state_e                 state_q;
  logic [4:0]             cnt_q;
  logic [FRAME_BITS-2:0]  rx_q;
  logic [FRAME_BITS-1:0]  rx_d;
  logic [DATA_W-1:0]      tx_q;
  logic                   lat_q;
  logic                   miso_q;
  logic                   oe_q;
  logic [DATA_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   wr_q;
  logic                   err_q;
  logic                   busy;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sclk (
    .clk   (clk),
    .rst   (rst),
    .d_i   (i_sclk),
    .q_o   (sclk_lvl_unused),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk   (clk),
    .rst   (rst),
    .d_i   (i_cs_n),
    .q_o   (cs_s),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_q <= '0;
    else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_mosi};
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // rx_q plus the incoming bit form the full 32-bit frame
  assign rx_d = {rx_q, mosi_s};
  assign busy = (state_q == HDR) || (state_q == RDLAT) ||
                (state_q == DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      lat_q   <= 1'b0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      oe_q  <= ~cs_s;
      if (cs_rise && busy) begin
        state_q <= IDLE;
        miso_q  <= 1'b0;
        err_q   <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall) begin
              cnt_q   <= '0;
              rx_q    <= '0;
              tx_q    <= '0;
              state_q <= HDR;
            end
          end
          HDR: begin
            if (sclk_rise) begin
              rx_q  <= rx_d[FRAME_BITS-2:0];
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == HDR_END) begin
                addr_q  <= {1'b0, rx_d[HDR_BITS-2:0]};
                lat_q   <= 1'b0;
                state_q <= rx_d[HDR_BITS-1] ? DATA : RDLAT;
              end
            end
          end
          RDLAT: begin
            // registered rdata is valid two cycles after o_addr moves
            if (lat_q) begin
              tx_q    <= i_rdata;
              state_q <= DATA;
            end else begin
              lat_q <= 1'b1;
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx_q  <= rx_d[FRAME_BITS-2:0];
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == FRAME_END) begin
                if (rx_d[RW_BIT]) begin
                  addr_q  <= {1'b0, rx_d[RW_BIT-1:HDR_BITS]};
                  wdata_q <= rx_d[HDR_BITS-1:0];
                  wr_q    <= 1'b1;
                end
                miso_q  <= 1'b0;
                state_q <= DONE;
              end
            end else if (sclk_fall) begin
              miso_q <= tx_q[DATA_W-1];
              tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
            end
          end
          DONE: begin
            miso_q <= 1'b0;
            if (cs_rise) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_miso      = miso_q;
  assign o_miso_oe   = oe_q;
  assign o_addr      = addr_q;
  assign o_wdata     = wdata_q;
  assign o_wr        = wr_q;
  assign o_frame_err = err_q;

endmodule
